// File: rtl/pwm.sv
// Free-running PWM generator: period counter compared against a duty register,
// with an optional triangle sweep of the duty applied once per period.
module pwm #(
    parameter int PERIOD    = 10,
    parameter int WIDTH     = 4,
    parameter int DUTY_INIT = 5,
    parameter int DUTY_STEP = 1,
    parameter int SWEEP_EN  = 0
) (
    input  logic clk,
    input  logic rst,
    output logic dout
);

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(PERIOD - 1);
    localparam logic [WIDTH-1:0] DUTY_MAX = WIDTH'(PERIOD);
    localparam logic [WIDTH-1:0] DUTY_RST = WIDTH'(DUTY_INIT);
    localparam logic [WIDTH-1:0] STEP     = WIDTH'(DUTY_STEP);
    localparam logic [WIDTH-1:0] UP_LIM   = WIDTH'(PERIOD - DUTY_STEP);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] duty;
    dir_t             dir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            duty <= DUTY_RST;
            dir  <= UP;
            dout <= 1'b0;
        end else begin
            dout <= (cnt < duty);
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                // Duty only moves on the wrap edge so each period sees one value
                if (SWEEP_EN != 0) begin
                    if (dir == UP) begin
                        if (duty >= UP_LIM) begin
                            duty <= DUTY_MAX;
                            dir  <= DOWN;
                        end else begin
                            duty <= duty + STEP;
                        end
                    end else begin
                        if (duty <= STEP) begin
                            duty <= '0;
                            dir  <= UP;
                        end else begin
                            duty <= duty - STEP;
                        end
                    end
                end
            end else begin
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: tb/tb_pwm.sv
// Directed bench for pwm: fixed duty, both duty extremes, a full triangle sweep,
// a saturating sweep, and asynchronous reset mid-period / mid-sweep.
module tb_pwm;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic d_def, d_zero, d_full, d_sw4, d_sat;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pwm u_def (.clk(clk), .rst(rst), .dout(d_def));

    pwm #(.PERIOD(10), .WIDTH(4), .DUTY_INIT(0)) u_zero (
        .clk(clk), .rst(rst), .dout(d_zero));

    pwm #(.PERIOD(10), .WIDTH(4), .DUTY_INIT(10)) u_full (
        .clk(clk), .rst(rst), .dout(d_full));

    pwm #(.PERIOD(4), .WIDTH(4), .DUTY_INIT(0), .DUTY_STEP(1), .SWEEP_EN(1)) u_sw4 (
        .clk(clk), .rst(rst), .dout(d_sw4));

    pwm #(.PERIOD(10), .WIDTH(4), .DUTY_INIT(8), .DUTY_STEP(3), .SWEEP_EN(1)) u_sat (
        .clk(clk), .rst(rst), .dout(d_sat));

    // Hand-derived duty per period after reset release
    int sw4_duty [8]  = '{0, 1, 2, 3, 4, 3, 2, 1};
    int sat_duty [11] = '{8, 10, 7, 4, 1, 0, 3, 6, 9, 10, 7};

    task automatic check(input string tag, input int k, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input int k, input int p, input int d);
        return (k % p) < d;
    endfunction

    task automatic check_all_low(input string tag);
        check({tag, "_def"},  -1, d_def,  1'b0);
        check({tag, "_zero"}, -1, d_zero, 1'b0);
        check({tag, "_full"}, -1, d_full, 1'b0);
        check({tag, "_sw4"},  -1, d_sw4,  1'b0);
        check({tag, "_sat"},  -1, d_sat,  1'b0);
    endtask

    // k counts rising edges since release; sampled on the following falling edge
    task automatic run_phase(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("def",  k, d_def,  exp_bit(k, 10, 5));
            check("zero", k, d_zero, 1'b0);
            check("full", k, d_full, 1'b1);
            check("sw4",  k, d_sw4,  exp_bit(k, 4, sw4_duty[(k / 4) % 8]));
            check("sat",  k, d_sat,  exp_bit(k, 10, sat_duty[k / 10]));
        end
    endtask

    initial begin
        @(negedge clk);
        check_all_low("rst_hold1");
        @(negedge clk);
        check_all_low("rst_hold2");
        rst = 1'b1;

        run_phase(103);

        // Mid-period (def/full high) and mid-sweep (sat descending) assertion
        #2;
        rst = 1'b0;
        #1;
        check_all_low("rst_async");
        repeat (3) begin
            @(negedge clk);
            check_all_low("rst_held");
        end
        rst = 1'b1;

        run_phase(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm.md
# pwm

Free-running pulse-width-modulation generator with no data inputs: an internal period counter is compared against an internal duty register to produce a single registered output, `dout`. The duty is either fixed at a parameterised value or swept up and down in a triangle pattern, one step per PWM period. It sits at the leaf of the design and drives an LED, enable line or similar load directly.

## Interface
- `PERIOD`, default 10: clocks per PWM period. Must be at least 2.
- `WIDTH`, default 4: width of the counter and duty registers. Must satisfy 2^WIDTH > PERIOD.
- `DUTY_INIT`, default 5: duty (high clocks per period) after reset. Range 0..PERIOD.
- `DUTY_STEP`, default 1: duty change per period when sweeping. Range 1..PERIOD.
- `SWEEP_EN`, default 0: 0 holds duty at `DUTY_INIT`; 1 enables the triangle sweep.
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  reset, asynchronous and active-low.
- `dout`  output  1  registered PWM output.

## Operation
- State:
  - `cnt`: WIDTH bits, range 0..PERIOD-1.
  - `duty`: WIDTH bits, range 0..PERIOD.
  - `dir`: 1 bit, up or down.
  - `dout`: 1 bit.
- Reset (`rst` low): `cnt`=0, `duty`=DUTY_INIT, `dir`=up, `dout`=0.
- Counter: `cnt` increments every clock. At `cnt`==PERIOD-1 it wraps to 0.
- Output: on every clock, `dout` <= (`cnt` < `duty`), using pre-edge values. The comparison is unsigned.
- Duty update happens only on the wrap edge (`cnt`==PERIOD-1), and only when SWEEP_EN=1. When SWEEP_EN=0, `duty` is constant.
  - `dir`=up, `duty` >= PERIOD-DUTY_STEP: `duty`=PERIOD, `dir`=down.
  - `dir`=up, otherwise: `duty` += DUTY_STEP.
  - `dir`=down, `duty` <= DUTY_STEP: `duty`=0, `dir`=up.
  - `dir`=down, otherwise: `duty` -= DUTY_STEP.
- Duty is held for one whole period. The new value first affects the compare at `cnt`=0, so every output period reflects exactly one duty value.
- `duty`=0 gives `dout` constantly 0. `duty`=PERIOD gives `dout` constantly 1.
- There is no glitching; `dout` comes straight from a flop.

## Timing
- Output latency: `dout` lags the compare by one clock. The first rising edge after reset release samples `cnt`=0, so `dout` = (0 < DUTY_INIT) from that edge onward.
- Output period: exactly PERIOD clocks. Within each period, `dout` is high for `duty` consecutive clocks, followed by PERIOD-`duty` low clocks.
- Reset assertion forces `dout`=0 immediately, without waiting for a clock, including mid-period and mid-sweep.
- Reset release is sampled on the next rising edge. Counting resumes from `cnt`=0 and the sweep restarts at DUTY_INIT with `dir`=up.
- Wrap edge and duty update coincide. There is no extra cycle between periods.

## Test plan
- Reset: hold `rst` low for 2 clocks, pulse it low mid-period, and hold it low while the clock runs. Required: `dout`=0 throughout, changing asynchronously at the assertion instant.
- Default parameters, 10 ns clock, `rst` released at 20 ns, run 200 ns. Required: `dout` is 1 for 5 clocks then 0 for 5 clocks, repeating with a 100 ns period; the first high begins at the first edge after release.
- DUTY_INIT=0: `dout` stays at 0. DUTY_INIT=PERIOD=10: `dout` stays at 1 from the first edge after release.
- SWEEP_EN=1, PERIOD=4, DUTY_INIT=0, DUTY_STEP=1. Required high-clock counts per period: 0,1,2,3,4,3,2,1,0,1,...
- Saturation: SWEEP_EN=1, PERIOD=10, DUTY_INIT=8, DUTY_STEP=3. Required duty per period: 8,10,7,4,1,0,3,6,9,10,7,...
- Sweep test from the previous item, reset mid-sweep (while `dir`=down). Required: after release, `duty` restarts at DUTY_INIT with `dir`=up, and the first period's high count equals DUTY_INIT.
